dpram_fifo_ctrl: RTL

//  Upstream controller that turns the 64x8 dual-port RAM into a first-word-fall-through FIFO.
//  - RAM port 1 is the write port.
//  - RAM port 2 is the read port.
//  - Producer and consumer sides each use a valid/ready handshake.
//  - The 1-cycle registered RAM read is hidden behind a 2-entry output skid buffer, so throughput is 1 word/cycle.

---
 rtl/dpram_pkg.sv | 26 ++
 rtl/dpram_fifo_skid.sv | 47 ++++
 rtl/dpram_fifo_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and types for the dual-port-RAM FIFO controller.
package dpram_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int SKID_DEPTH = 2;
    localparam int MAX_COUNT  = DEPTH + SKID_DEPTH;
    localparam int CNT_W      = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [1:0]        skid_cnt_t;

    // True when the skid buffer can absorb one more read. The read issued now
    // lands one edge after the one already in flight, so count that one too.
    function automatic logic fetch_room(input skid_cnt_t skid_cnt,
                                        input logic      fetch_pend,
                                        input logic      pop);
        logic [2:0] occupancy;
        occupancy = {1'b0, skid_cnt} + {2'b00, fetch_pend} - {2'b00, pop};
        return occupancy < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/dpram_fifo_skid.sv
// Two-entry in-order output buffer that hides the registered RAM read.
module dpram_fifo_skid
    import dpram_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] capture_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        skid_cnt
);

    logic [DATA_W-1:0] entry_reg [SKID_DEPTH];
    logic [1:0]        cnt_reg;

    // Entry 0 is always the head. The controller never captures into a full
    // buffer unless a pop frees a slot in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_reg <= 2'd0;
        end else if (capture && pop) begin
            if (cnt_reg == 2'd2) begin
                entry_reg[0] <= entry_reg[1];
                entry_reg[1] <= capture_data;
            end else begin
                entry_reg[0] <= capture_data;
            end
        end else if (capture) begin
            if (cnt_reg == 2'd0) begin
                entry_reg[0] <= capture_data;
            end else begin
                entry_reg[1] <= capture_data;
            end
            cnt_reg <= cnt_reg + 2'd1;
        end else if (pop) begin
            entry_reg[0] <= entry_reg[1];
            cnt_reg      <= cnt_reg - 2'd1;
        end
    end

    assign out_valid = (cnt_reg != 2'd0);
    assign out_data  = entry_reg[0];
    assign skid_cnt  = cnt_reg;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller built around a 64x8 dual-port RAM.
// Port 1 writes, port 2 reads; a 2-entry skid buffer hides the read latency.
module dpram_fifo_ctrl
    import dpram_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] ram_address_1,
    output logic [DATA_W-1:0] ram_write_data_1,
    output logic              ram_write_enable_1,
    output logic [ADDR_W-1:0] ram_address_2,
    output logic [DATA_W-1:0] ram_write_data_2,
    output logic              ram_write_enable_2,
    input  logic [DATA_W-1:0] ram_read_data_2
);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  mem_cnt_reg;
    logic [CNT_W-1:0]  mem_cnt_next;
    logic              fetch_pend_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [1:0]        skid_cnt;
    logic [1:0]        skid_cnt_next;
    logic              push;
    logic              pop;
    logic              fetch;

    // Handshakes. A word counts in mem_cnt only after its write edge, so the
    // read of that address is issued at the following edge at the earliest.
    assign in_ready = reset_n & (mem_cnt_reg != CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign fetch    = (mem_cnt_reg != '0) & fetch_room(skid_cnt, fetch_pend_reg, pop);

    // Occupancy bookkeeping for the registered count output.
    assign mem_cnt_next  = mem_cnt_reg + CNT_W'(push) - CNT_W'(fetch);
    assign skid_cnt_next = skid_cnt + 2'(fetch_pend_reg) - 2'(pop);
    assign count_next    = mem_cnt_next + CNT_W'(fetch) + CNT_W'(skid_cnt_next);

    // Pointer, in-flight read and count state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_cnt_reg    <= '0;
            fetch_pend_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (fetch) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            mem_cnt_reg    <= mem_cnt_next;
            fetch_pend_reg <= fetch;
            count_reg      <= count_next;
        end
    end

    dpram_fifo_skid u_skid (
        .clock        (clock),
        .reset_n      (reset_n),
        .capture      (fetch_pend_reg),
        .capture_data (ram_read_data_2),
        .pop          (pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .skid_cnt     (skid_cnt)
    );

    assign count              = count_reg;
    assign ram_address_1      = wr_ptr_reg;
    assign ram_write_data_1   = in_data;
    assign ram_write_enable_1 = push;
    assign ram_address_2      = rd_ptr_reg;
    assign ram_write_data_2   = '0;
    assign ram_write_enable_2 = 1'b0;

endmodule
